// File: rtl/sha256_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sha256_pkg : round constants, IVs, state types and round helper functions
// Revision   : 1.0
// ---------------------------------------------------------------------------
package sha256_pkg;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV256 =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] IV224 =
    256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

  // Field a sits in the top word so a packed state maps directly onto H0..H7.
  typedef struct packed {
    logic [31:0] a, b, c, d, e, f, g, h;
  } sha_state_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2,
    S_OUT   = 2'd3
  } fsm_state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic sha_state_t sha256_round(input sha_state_t s, input logic [31:0] w,
                                              input logic [31:0] k);
    logic [31:0] t1;
    logic [31:0] t2;
    sha_state_t  n;
    t1  = s.h + big_sigma1(s.e) + ch(s.e, s.f, s.g) + k + w;
    t2  = big_sigma0(s.a) + maj(s.a, s.b, s.c);
    n.a = t1 + t2;
    n.b = s.a;
    n.c = s.b;
    n.d = s.c;
    n.e = s.d + t1;
    n.f = s.e;
    n.g = s.f;
    n.h = s.g;
    return n;
  endfunction

  function automatic sha_state_t add_state(input sha_state_t x, input sha_state_t y);
    sha_state_t r;
    r.a = x.a + y.a;
    r.b = x.b + y.b;
    r.c = x.c + y.c;
    r.d = x.d + y.d;
    r.e = x.e + y.e;
    r.f = x.f + y.f;
    r.g = x.g + y.g;
    r.h = x.h + y.h;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_round_comb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sha256_round_comb : one combinational SHA-256 round (state + W + K -> state)
// Revision          : 1.0
// ---------------------------------------------------------------------------
module sha256_round_comb
  import sha256_pkg::*;
(
  input  logic [255:0] state_i,
  input  logic [31:0]  w_i,
  input  logic [31:0]  k_i,
  output logic [255:0] state_o
);

  assign state_o = sha256_round(sha_state_t'(state_i), w_i, k_i);

endmodule
`default_nettype wire

// File: rtl/sha256_block_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sha256_block_engine : chained SHA-256 compression, ROUNDS_PER_CYCLE rounds/clk
// Option macro SHA256_BLOCK_ENGINE_SHA224_EN adds in_sha224 (SHA-224 mode).
// Revision            : 1.0
// ---------------------------------------------------------------------------
module sha256_block_engine
  import sha256_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_first,
  input  logic [511:0] in_block,
`ifdef SHA256_BLOCK_ENGINE_SHA224_EN
  input  logic         in_sha224,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_digest,
  output logic         busy
);

  localparam int          R        = ROUNDS_PER_CYCLE;
  localparam logic [5:0]  LAST_CNT = 6'(64 - R);
  localparam logic [5:0]  CNT_STEP = 6'(R);

  fsm_state_t   state_q, state_d;
  sha_state_t   h_q, h_d;
  sha_state_t   st_q, st_d;
  logic [31:0]  w_q [16];
  logic [31:0]  w_d [16];
  logic [5:0]   cnt_q, cnt_d;
  logic [255:0] dig_q, dig_d;
  logic [31:0]  w_rnd [R];
  logic [31:0]  w_shift [16];
  logic [255:0] rounds_out;
  sha_state_t   sum;
  sha_state_t   h_load;
  logic         load_224;

`ifdef SHA256_BLOCK_ENGINE_SHA224_EN
  logic mode_q, mode_d;
  assign load_224 = in_first ? in_sha224 : mode_q;
`else
  logic mode_q;
  assign mode_q   = 1'b0;
  assign load_224 = 1'b0;
`endif

  // Extended window: words 16..16+R-1 are the next schedule words, built in order
  // so later ones can use earlier ones within the same cycle.
  always_comb begin
    logic [31:0] ext [16+R];
    for (int i = 0; i < 16; i++) ext[i] = w_q[i];
    for (int j = 0; j < R; j++)
      ext[16+j] = ext[j] + small_sigma0(ext[j+1]) + ext[j+9] + small_sigma1(ext[j+14]);
    for (int j = 0; j < R; j++) w_rnd[j] = ext[j];
    for (int i = 0; i < 16; i++) w_shift[i] = ext[i+R];
  end

  for (genvar j = 0; j < R; j++) begin : g_round
    logic [255:0] st_in;
    logic [255:0] st_out;
    if (j == 0) begin : g_first
      assign st_in = st_q;
    end else begin : g_next
      assign st_in = g_round[j-1].st_out;
    end
    sha256_round_comb u_round (
      .state_i (st_in),
      .w_i     (w_rnd[j]),
      .k_i     (K[cnt_q + 6'(j)]),
      .state_o (st_out)
    );
  end
  assign rounds_out = g_round[R-1].st_out;

  assign sum    = add_state(h_q, st_q);
  assign h_load = in_first ? sha_state_t'(load_224 ? IV224 : IV256) : h_q;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    st_d    = st_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
`ifdef SHA256_BLOCK_ENGINE_SHA224_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < 16; i++) w_d[i] = in_block[511-32*i -: 32];
          h_d     = h_load;
          st_d    = h_load;
          cnt_d   = '0;
          state_d = S_ROUND;
`ifdef SHA256_BLOCK_ENGINE_SHA224_EN
          mode_d  = load_224;
`endif
        end
      end
      S_ROUND: begin
        st_d  = sha_state_t'(rounds_out);
        w_d   = w_shift;
        cnt_d = cnt_q + CNT_STEP;
        if (cnt_q == LAST_CNT) state_d = S_FINAL;
      end
      S_FINAL: begin
        h_d     = sum;
        dig_d   = mode_q ? {sum[255:32], 32'h0} : sum;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      h_q     <= sha_state_t'(IV256);
      st_q    <= '0;
      w_q     <= '{default: '0};
      cnt_q   <= '0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      st_q    <= st_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
    end
  end

`ifdef SHA256_BLOCK_ENGINE_SHA224_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) mode_q <= 1'b0;
    else       mode_q <= mode_d;
  end
`endif

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_OUT);
  assign busy       = (state_q != S_IDLE);
  assign out_digest = dig_q;

endmodule
`default_nettype wire
